// File: rtl/pol2rec_pkg.sv
// Shared constants, FSM state type and saturation helper for the polar-to-rectangular CORDIC.
// The CORDIC constants here are meant to be reused by rec2pol as well.
package pol2rec_pkg;

    localparam int ITER_DEFAULT = 24;

    // 1/K for the CORDIC gain, Q1.31
    localparam logic signed [31:0] KINV = 32'sh4DBA76D4;

    // 90 and 180 degrees in the Q9.24 angle accumulator format
    localparam logic signed [32:0] A90  = 33'sd1509949440;
    localparam logic signed [32:0] A180 = 33'sd3019898880;

    typedef enum logic [1:0] {
        IDLE,
        ROT,
        DONE
    } state_t;

    function automatic logic [31:0] sat32(input logic signed [33:0] v);
        if (v > 34'sd2147483647) begin
            return 32'h7FFFFFFF;
        end else if (v < -34'sd2147483648) begin
            return 32'h80000000;
        end
        return v[31:0];
    endfunction

endpackage

// File: rtl/pol2rec_atan_rom.sv
// Combinational table of atan(2^-i) in degrees, Q8.24, for CORDIC micro-rotation i.
module pol2rec_atan_rom (
    input  logic [4:0]  idx,
    output logic [31:0] atan
);

    always_comb begin
        case (idx)
            5'd0:    atan = 32'h2D000000;
            5'd1:    atan = 32'h1A90A731;
            5'd2:    atan = 32'h0E094740;
            5'd3:    atan = 32'h07200112;
            5'd4:    atan = 32'h03938AA6;
            5'd5:    atan = 32'h01CA3795;
            5'd6:    atan = 32'h00E52A1B;
            5'd7:    atan = 32'h007296D8;
            5'd8:    atan = 32'h00394BA5;
            5'd9:    atan = 32'h001CA5DA;
            5'd10:   atan = 32'h000E52ED;
            5'd11:   atan = 32'h00072976;
            5'd12:   atan = 32'h000394BB;
            5'd13:   atan = 32'h0001CA5E;
            5'd14:   atan = 32'h0000E52F;
            5'd15:   atan = 32'h00007297;
            5'd16:   atan = 32'h0000394C;
            5'd17:   atan = 32'h00001CA6;
            5'd18:   atan = 32'h00000E53;
            5'd19:   atan = 32'h00000729;
            5'd20:   atan = 32'h00000395;
            5'd21:   atan = 32'h000001CA;
            5'd22:   atan = 32'h000000E5;
            5'd23:   atan = 32'h00000073;
            5'd24:   atan = 32'h00000039;
            5'd25:   atan = 32'h0000001D;
            5'd26:   atan = 32'h0000000E;
            5'd27:   atan = 32'h00000007;
            5'd28:   atan = 32'h00000004;
            5'd29:   atan = 32'h00000002;
            5'd30:   atan = 32'h00000001;
            default: atan = 32'h00000000;
        endcase
    end

endmodule

// File: rtl/pol2rec.sv
// Iterative rotation-mode CORDIC: polar (Q16.16 modulus, Q8.24 degrees) to rectangular Q16.16.
// One micro-rotation per enabled clock; ITER must stay within 16..32.
module pol2rec
    import pol2rec_pkg::*;
#(
    parameter int ITER = ITER_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        start,
    input  logic [31:0] mod,
    input  logic [31:0] angle,
    output logic [31:0] x,
    output logic [31:0] y,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST = 5'(ITER - 1);

    state_t             state;
    logic [4:0]         i;
    logic signed [33:0] xr;
    logic signed [33:0] yr;
    logic signed [32:0] zr;

    logic signed [33:0] xs;
    logic signed [33:0] x0;
    logic signed [32:0] ang;
    logic signed [32:0] z0;
    logic [31:0]        atan_i;
    logic signed [32:0] step;
    logic signed [33:0] x_sh;
    logic signed [33:0] y_sh;
    logic               dir_pos;

    // Pre-divide by the CORDIC gain so the rotated vector comes out at the true modulus
    assign xs  = 34'((64'(signed'(mod)) * 64'(KINV)) >>> 31);
    assign ang = 33'(signed'(angle));

    // Angles beyond +/-90 degrees are folded by 180 so the iterations only cover their convergent range
    always_comb begin
        x0 = xs;
        z0 = ang;
        if (ang > A90) begin
            x0 = -xs;
            z0 = ang - A180;
        end else if (ang < -A90) begin
            x0 = -xs;
            z0 = ang + A180;
        end
    end

    pol2rec_atan_rom u_atan_rom (
        .idx  (i),
        .atan (atan_i)
    );

    assign step    = 33'(signed'(atan_i));
    assign dir_pos = ~zr[32];
    assign x_sh    = xr >>> i;
    assign y_sh    = yr >>> i;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            i     <= '0;
            xr    <= '0;
            yr    <= '0;
            zr    <= '0;
            x     <= '0;
            y     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else if (enable) begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        xr    <= x0;
                        yr    <= '0;
                        zr    <= z0;
                        i     <= '0;
                        busy  <= 1'b1;
                        state <= ROT;
                    end
                end
                ROT: begin
                    if (dir_pos) begin
                        xr <= xr - y_sh;
                        yr <= yr + x_sh;
                        zr <= zr - step;
                    end else begin
                        xr <= xr + y_sh;
                        yr <= yr - x_sh;
                        zr <= zr + step;
                    end
                    i <= i + 5'd1;
                    if (i == LAST) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    x     <= sat32(xr);
                    y     <= sat32(yr);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
